// File: rtl/commit_bus_arbiter_pkg.sv
// Shared widths and commit packet layout for the commit bus arbiter,
// the reservation stations that snoop the bus and the register file.
// Every consumer slices the bus with the *_LSB offsets defined here.
package commit_bus_arbiter_pkg;

    localparam int NUM_RS = 8;
    localparam int DATA_W = 96;
    localparam int ADDR_W = 8;
    localparam int TAG_W  = 4;
    localparam int RSID_W = 4;
    localparam int WE_W   = 3;
    localparam int IDX_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    // Packet is {RSID, TAG, WE, DEST, DATA}, MSB first.
    localparam int DATA_LSB = 0;
    localparam int DEST_LSB = DATA_LSB + DATA_W;
    localparam int WE_LSB   = DEST_LSB + ADDR_W;
    localparam int TAG_LSB  = WE_LSB + WE_W;
    localparam int RSID_LSB = TAG_LSB + TAG_W;
    localparam int PKT_W    = RSID_LSB + RSID_W;

    // Stations read source RS 0 as "no dependency", so RSID 0 means no commit.
    localparam logic [RSID_W-1:0] RSID_NONE = '0;

    typedef struct packed {
        logic [RSID_W-1:0] rsid;
        logic [TAG_W-1:0]  tag;
        logic [WE_W-1:0]   we;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } commit_pkt_t;

endpackage

// File: rtl/commit_bus_arbiter_if.sv
// Request/result and commit bus bundle between the reservation stations and
// the commit bus arbiter. Per-station fields are flattened, station k at
// slice k. master = arbiter side, slave = station/register-file side.
interface commit_bus_if;
    import commit_bus_arbiter_pkg::*;

    logic [NUM_RS-1:0]        commit_request;
    logic [RSID_W*NUM_RS-1:0] id;
    logic [TAG_W*NUM_RS-1:0]  tag;
    logic [WE_W*NUM_RS-1:0]   we;
    logic [ADDR_W*NUM_RS-1:0] destination;
    logic [DATA_W*NUM_RS-1:0] result;
    logic                     stall;
    logic [NUM_RS-1:0]        commit_granted;
    logic                     commit_valid;
    logic [PKT_W-1:0]         commit_bus;
    logic [15:0]              grant_count;

    modport master (
        input  commit_request, id, tag, we, destination, result, stall,
        output commit_granted, commit_valid, commit_bus, grant_count
    );

    modport slave (
        output commit_request, id, tag, we, destination, result, stall,
        input  commit_granted, commit_valid, commit_bus, grant_count
    );

endinterface

// File: rtl/commit_bus_arbiter_rr_priority_select.sv
// Round-robin priority select: first set request scanning upward from ptr+1,
// wrapping. Outputs one-hot grant, its encoded index and an any-grant flag.
// Purely combinational, zero latency; no backpressure of its own.
module rr_priority_select #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        // Offsets 1..N visit every station once, ending at ptr itself.
        for (int i = 1; i <= N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/commit_bus_arbiter.sv
// Commit bus arbiter: round-robin grant of one reservation station per cycle,
// registered commit bus one cycle after the combinational grant pulse.
// Ports: clk, rst (sync, active-high), cb (commit_bus_if master side).
module commit_bus_arbiter
    import commit_bus_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    commit_bus_if.master cb
);

    logic [IDX_W-1:0]  ptr;
    logic [NUM_RS-1:0] req_q;
    logic [NUM_RS-1:0] gnt;
    logic [IDX_W-1:0]  sel_idx;
    logic              any_grant;
    int                sel;
    commit_pkt_t       pkt;
    commit_pkt_t       bus_r;
    logic              valid_r;
    logic [15:0]       grant_cnt;

    // Stall and reset kill the grant in the same cycle; stations keep requesting.
    assign req_q = (rst || cb.stall) ? '0 : cb.commit_request;

    rr_priority_select #(
        .N  (NUM_RS),
        .IW (IDX_W)
    ) u_select (
        .req (req_q),
        .ptr (ptr),
        .gnt (gnt),
        .idx (sel_idx),
        .any (any_grant)
    );

    always_comb begin
        sel      = int'(sel_idx);
        pkt      = '0;
        pkt.rsid = cb.id[sel*RSID_W +: RSID_W];
        pkt.tag  = cb.tag[sel*TAG_W +: TAG_W];
        pkt.we   = cb.we[sel*WE_W +: WE_W];
        pkt.dest = cb.destination[sel*ADDR_W +: ADDR_W];
        pkt.data = cb.result[sel*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= IDX_W'(NUM_RS - 1);
            bus_r     <= '0;
            valid_r   <= 1'b0;
            grant_cnt <= '0;
        end else if (any_grant) begin
            ptr     <= sel_idx;
            bus_r   <= pkt;
            valid_r <= 1'b1;
            if (grant_cnt != 16'hFFFF) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
        end else begin
            // Idle cycles drive RSID_NONE so snoopers never see a stale commit.
            bus_r      <= '0;
            bus_r.rsid <= RSID_NONE;
            valid_r    <= 1'b0;
        end
    end

    assign cb.commit_granted = gnt;
    assign cb.commit_bus     = bus_r;
    assign cb.commit_valid   = valid_r;
    assign cb.grant_count    = grant_cnt;

    // Station k must present RSID k+1; the bus always carries iId as given.
    a_rsid_consistent: assert property (@(posedge clk) disable iff (rst)
        any_grant |-> (pkt.rsid == (RSID_W'(sel_idx) + RSID_W'(1))));

endmodule

// File: doc/commit_bus_arbiter.md
Name: commit_bus_arbiter

Overview:
- Sits directly downstream of the reservation stations and arbitrates their commit requests.
- Grants one station per cycle, round-robin, and samples that station's result packet.
- Drives the registered commit bus, which feeds the register file write port and is snooped by every reservation station for operand forwarding.
- RSID 0 on the bus means "no commit", because stations treat source RS 0 as "no dependency".

Parameters:
- NUM_RS, 8, number of reservation stations; station k (0-based port index) has RSID k+1; max 15.
- DATA_W, 96, result row width (3 x 32-bit lanes).
- ADDR_W, 8, destination register address width.
- TAG_W, 4, source tag width carried with the result.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- iCommitRequest  in  NUM_RS  per-station request; held high until granted.
- iId  in  4*NUM_RS  per-station RSID, flattened with station k at [4k+3:4k].
- iTag  in  TAG_W*NUM_RS  per-station result tag.
- iWE  in  3*NUM_RS  per-station lane write enables.
- iDestination  in  ADDR_W*NUM_RS  per-station destination address.
- iResult  in  DATA_W*NUM_RS  per-station result data.
- iStall  in  1  register file cannot accept a write this cycle.
- oCommitGranted  out  NUM_RS  one-hot grant pulse, combinational in the request cycle.
- oCommitValid  out  1  commit bus carries a valid write.
- oCommitBus  out  4+TAG_W+3+ADDR_W+DATA_W  packet {RSID, TAG, WE, DEST, DATA}, MSB first.
- oGrantCount  out  16  saturating count of commits since reset (debug/perf).

Behaviour:
- Clock and reset: single clock domain; reset is synchronous, active-high.
- Reset values: round-robin pointer = NUM_RS-1, so station 0 has top priority first; oCommitBus = 0; oCommitValid = 0; oGrantCount = 0. oCommitGranted is forced to 0 while Reset is high.
- Grant (cycle T):
  - If iStall = 0 and any request is high, exactly one bit of oCommitGranted is set.
  - The winner is the first requesting index scanning upward from pointer+1, wrapping modulo NUM_RS.
  - If iStall = 1 or there are no requests, oCommitGranted = 0.
- Pointer: on a grant, the pointer becomes the granted index at the T+1 edge; otherwise it is unchanged.
- Bus (T+1):
  - On a grant, oCommitBus is loaded with the winner's {iId, iTag, iWE, iDestination, iResult} as sampled at T, and oCommitValid = 1.
  - With no grant, the next edge loads oCommitBus = 0 (RSID 0, WE 0) and oCommitValid = 0. The bus never repeats a stale packet.
- Latency: exactly 1 cycle from grant to bus valid. Back-to-back grants give one commit per cycle, sustained.
- Fairness: a continuously requesting station is granted within NUM_RS cycles of its request, given no stall.
- Stall:
  - iStall suppresses grants combinationally in the same cycle.
  - Requests stay pending, since stations hold them; no packet is lost.
  - Stall does not move the pointer.
- Request dropped without a grant: legal; that station is simply not considered.
- Single requester: granted every cycle it requests, regardless of pointer position.
- Consistency check: iId of station k should equal k+1. The RSID placed on the bus is always taken from iId. A simulation-only assertion flags a mismatch.
- oGrantCount: increments by 1 on each grant edge; saturates at 16'hFFFF.
- Reset mid-operation: a grant in the reset cycle is suppressed and bus contents are discarded; stations must re-request.

Decomposition:
- Shared package: the widths (DATA_W, ADDR_W, TAG_W, RSID width 4), the commit packet field offsets (RSID / TAG / WE / DEST / DATA ranges), and the constant RSID_NONE = 0. Reservation stations and the register file slice the bus using the same offsets.
- One sub-module: rr_priority_select (NUM_RS requests plus pointer in, one-hot grant plus encoded index out; purely combinational).
- Top level contains the pointer register, packet mux, output registers and counter.

Test Plan:
- Reset, then a single request on station 2 with DATA=96'h1 and DEST=8'h10 -> oCommitGranted=8'b0000_0100 same cycle; next cycle oCommitBus RSID=3, DEST=8'h10, DATA=1, oCommitValid=1; the following idle cycle shows RSID=0, oCommitValid=0.
- All 8 stations request continuously for 16 cycles -> grant order 0,1,...,7,0,...,7; each station granted twice; oGrantCount=16.
- Stations 1 and 5 request and the pointer is at 3 -> grant goes to 5 first, then 1; neither waits more than 2 cycles.
- iStall=1 for 3 cycles with stations 0 and 4 pending -> no grants, bus RSID=0 and pointer unchanged throughout; on release, station 0 is granted, then 4.
- Reset asserted in the same cycle as a request on station 6 -> oCommitGranted=0 and the bus stays 0; after reset the station re-requests and is granted with RSID=7.
- 70000 back-to-back commits -> oGrantCount holds at 16'hFFFF.
